traffic_light_ctrl: RTL and testbench

// - Two-road (NS/EW) traffic-light sequencer. Sits directly downstream of the 1 Hz clock divider.
// - Consumes the divider's 50%-duty clk_out as the data input sec_in, sampled in the clk domain.
//   sec_in is never used as a clock.
// - Produces lamp drives, current phase, and seconds-remaining for the countdown display stage.
// - Pedestrian request shortens the current green.

---
 rtl/traffic_pkg.sv | 66 ++++++
 rtl/sec_tick_detect.sv | 32 +++
 rtl/traffic_light_ctrl.sv | 107 ++++++++++
 tb/tb_traffic_light_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// -----------------------------------------------------------------------------
// traffic_pkg
// Shared definitions for the two-road traffic-light sequencer and its
// downstream display stages.
//   - state_t  : phase encoding (NS_G=0 .. AR2=5), also driven out on 'phase'
//   - L_*      : lamp drive constants {red,yellow,green}
//   - phase_dur: duration lookup (seconds) for a given phase
//   - next_phase, ns_lamp, ew_lamp: cyclic successor and lamp decode
// -----------------------------------------------------------------------------
package traffic_pkg;

  typedef enum logic [2:0] {
    NS_G = 3'd0,
    NS_Y = 3'd1,
    AR1  = 3'd2,
    EW_G = 3'd3,
    EW_Y = 3'd4,
    AR2  = 3'd5
  } state_t;

  localparam logic [2:0] L_RED = 3'b100;
  localparam logic [2:0] L_YEL = 3'b010;
  localparam logic [2:0] L_GRN = 3'b001;

  // Durations are passed in because the package cannot see module parameters.
  function automatic int unsigned phase_dur(input state_t s,
                                            input int unsigned t_green,
                                            input int unsigned t_yellow,
                                            input int unsigned t_allred);
    case (s)
      NS_G, EW_G: return t_green;
      NS_Y, EW_Y: return t_yellow;
      AR1, AR2:   return t_allred;
      default:    return t_allred;
    endcase
  endfunction

  function automatic state_t next_phase(input state_t s);
    case (s)
      NS_G:    return NS_Y;
      NS_Y:    return AR1;
      AR1:     return EW_G;
      EW_G:    return EW_Y;
      EW_Y:    return AR2;
      AR2:     return NS_G;
      default: return AR2;
    endcase
  endfunction

  function automatic logic [2:0] ns_lamp(input state_t s);
    case (s)
      NS_G:    return L_GRN;
      NS_Y:    return L_YEL;
      default: return L_RED;
    endcase
  endfunction

  function automatic logic [2:0] ew_lamp(input state_t s);
    case (s)
      EW_G:    return L_GRN;
      EW_Y:    return L_YEL;
      default: return L_RED;
    endcase
  endfunction

endpackage

// File: rtl/sec_tick_detect.sv
// -----------------------------------------------------------------------------
// sec_tick_detect
// Rising-edge detector for a slow level (the 1 Hz divider output), sampled as
// data in the clk domain. Both sources share clk, so no synchroniser is used.
//   clk      in  system clock
//   rst      in  synchronous reset, active-high
//   level_in in  slow level to watch
//   tick     out one-clk registered pulse, one clk after each rising edge
// The history register resets high so a level that is already high at reset
// release does not produce a spurious tick.
// -----------------------------------------------------------------------------
module sec_tick_detect (
  input  logic clk,
  input  logic rst,
  input  logic level_in,
  output logic tick
);

  logic sec_q;

  // Level history and registered rising-edge pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      sec_q <= 1'b1;
      tick  <= 1'b0;
    end else begin
      sec_q <= level_in;
      tick  <= level_in & ~sec_q;
    end
  end

endmodule

// File: rtl/traffic_light_ctrl.sv
// -----------------------------------------------------------------------------
// traffic_light_ctrl
// Two-road (NS/EW) traffic-light sequencer driven by one-second ticks derived
// from the divider output. A pedestrian request shortens the current (or next)
// green to at most T_PED further seconds.
//   clk      in  system clock
//   rst      in  synchronous reset, active-high
//   sec_in   in  divider output (data, not a clock); rising edge = one second
//   ped_req  in  pedestrian request level, sampled every clk
//   ns_light out {red,yellow,green} NS lamps, one-hot, registered
//   ew_light out {red,yellow,green} EW lamps, one-hot, registered
//   phase    out current state (traffic_pkg::state_t encoding)
//   remain   out seconds left in phase minus one (0 = last second)
//   tick     out one-clk pulse per detected sec_in rising edge
// -----------------------------------------------------------------------------
module traffic_light_ctrl
  import traffic_pkg::*;
#(
  parameter int unsigned T_GREEN  = 25,
  parameter int unsigned T_YELLOW = 3,
  parameter int unsigned T_ALLRED = 2,
  parameter int unsigned T_PED    = 4,
  parameter int unsigned CNT_W    = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sec_in,
  input  logic             ped_req,
  output logic [2:0]       ns_light,
  output logic [2:0]       ew_light,
  output logic [2:0]       phase,
  output logic [CNT_W-1:0] remain,
  output logic             tick
);

  // Elaboration-time parameter sanity.
  if ((T_GREEN - 32'd1) >= (64'd1 << CNT_W)) begin : g_err_cnt_w
    $error("traffic_light_ctrl: CNT_W too small to hold T_GREEN-1");
  end
  if (T_PED >= T_GREEN) begin : g_err_ped
    $error("traffic_light_ctrl: T_PED must be smaller than T_GREEN");
  end
  if ((T_GREEN < 32'd2) || (T_YELLOW < 32'd1) || (T_ALLRED < 32'd1)) begin : g_err_dur
    $error("traffic_light_ctrl: phase duration out of range");
  end

  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] PED_LIM  = CNT_W'(T_PED);
  localparam logic [CNT_W-1:0] AR_LOAD  = CNT_W'(T_ALLRED - 32'd1);

  state_t           state;
  state_t           nxt_state;
  logic             ped_pend;
  logic [CNT_W-1:0] nxt_load;
  logic             nxt_is_yel;
  logic             cur_is_grn;

  sec_tick_detect u_tick (
    .clk      (clk),
    .rst      (rst),
    .level_in (sec_in),
    .tick     (tick)
  );

  assign nxt_state  = next_phase(state);
  assign nxt_load   = CNT_W'(phase_dur(nxt_state, T_GREEN, T_YELLOW, T_ALLRED) - 32'd1);
  assign nxt_is_yel = (nxt_state == NS_Y) || (nxt_state == EW_Y);
  assign cur_is_grn = (state == NS_G) || (state == EW_G);
  assign phase      = state;

  // Phase sequencer, countdown, pedestrian latch and registered lamp drives.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= AR2;
      remain   <= AR_LOAD;
      ns_light <= L_RED;
      ew_light <= L_RED;
      ped_pend <= 1'b0;
    end else begin
      // Request set takes priority over the clear on yellow entry.
      if (ped_req) begin
        ped_pend <= 1'b1;
      end else if (tick && (remain == CNT_ZERO) && nxt_is_yel) begin
        ped_pend <= 1'b0;
      end else begin
        ped_pend <= ped_pend;
      end

      if (tick) begin
        if (remain == CNT_ZERO) begin
          state    <= nxt_state;
          remain   <= nxt_load;
          ns_light <= ns_lamp(nxt_state);
          ew_light <= ew_lamp(nxt_state);
        end else if (cur_is_grn && ped_pend && (remain > PED_LIM)) begin
          remain <= PED_LIM;
        end else begin
          remain <= remain - CNT_ONE;
        end
      end else begin
        remain <= remain;
      end
    end
  end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// -----------------------------------------------------------------------------
// tb_traffic_light_ctrl
// Scoreboard bench for traffic_light_ctrl with short test durations
// (T_GREEN=4, T_YELLOW=2, T_ALLRED=1, T_PED=1). Expected {phase,remain} steps
// are queued as stimulus is applied and popped on the clk after each observed
// tick. Every clk also checks lamp exclusivity, tick width and hold between
// ticks.
// -----------------------------------------------------------------------------
module tb_traffic_light_ctrl;
  import traffic_pkg::*;

  localparam int unsigned CNT_W = 6;

  typedef struct packed {
    logic [2:0]       st;
    logic [CNT_W-1:0] rem;
  } exp_t;

  logic             clk;
  logic             rst;
  logic             sec_in;
  logic             ped_req;
  logic [2:0]       ns_light;
  logic [2:0]       ew_light;
  logic [2:0]       phase;
  logic [CNT_W-1:0] remain;
  logic             tick;

  exp_t             sb_q[$];
  int               errors;
  int               checks;
  int               sec_cnt;
  bit               sec_run;
  logic             prev_tick;
  logic [2:0]       last_phase;
  logic [CNT_W-1:0] last_remain;

  traffic_light_ctrl #(
    .T_GREEN  (4),
    .T_YELLOW (2),
    .T_ALLRED (1),
    .T_PED    (1),
    .CNT_W    (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sec_in   (sec_in),
    .ped_req  (ped_req),
    .ns_light (ns_light),
    .ew_light (ew_light),
    .phase    (phase),
    .remain   (remain),
    .tick     (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected {ns,ew} lamps for a phase code.
  function automatic logic [5:0] exp_lamps(input logic [2:0] st);
    case (st)
      3'd0:    return {3'b001, 3'b100};
      3'd1:    return {3'b010, 3'b100};
      3'd2:    return {3'b100, 3'b100};
      3'd3:    return {3'b100, 3'b001};
      3'd4:    return {3'b100, 3'b010};
      3'd5:    return {3'b100, 3'b100};
      default: return 6'b000000;
    endcase
  endfunction

  task automatic push(input logic [2:0] st, input logic [CNT_W-1:0] rem);
    exp_t e;
    e.st  = st;
    e.rem = rem;
    sb_q.push_back(e);
  endtask

  // One clk: sample after the edge, compare, then advance the sec_in wave.
  task automatic cycle();
    logic       rst_edge;
    logic       tick_before;
    exp_t       e;
    logic [5:0] lamps;
    rst_edge    = rst;
    tick_before = prev_tick;
    @(posedge clk);
    #1;
    check("lamp_conflict", 32'((ns_light != 3'b100) && (ew_light != 3'b100)), 32'd0);
    if (rst_edge) begin
      prev_tick = 1'b0;
    end else begin
      if (tick_before) begin
        check("tick_width", 32'(tick), 32'd0);
        if (sb_q.size() == 0) begin
          check("unexpected_step", 32'd1, 32'd0);
        end else begin
          e     = sb_q.pop_front();
          lamps = exp_lamps(e.st);
          check("phase", 32'(phase), 32'(e.st));
          check("remain", 32'(remain), 32'(e.rem));
          check("ns_light", 32'(ns_light), 32'(lamps[5:3]));
          check("ew_light", 32'(ew_light), 32'(lamps[2:0]));
        end
      end else begin
        check("hold_phase", 32'(phase), 32'(last_phase));
        check("hold_remain", 32'(remain), 32'(last_remain));
      end
      prev_tick = tick;
    end
    last_phase  = phase;
    last_remain = remain;
    if (sec_run) begin
      sec_cnt++;
      sec_in = ((sec_cnt % 10) >= 5);
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((sb_q.size() != 0) && (n < budget)) begin
      cycle();
      n++;
    end
    if (sb_q.size() != 0) begin
      check("drain_timeout", 32'(sb_q.size()), 32'd0);
      sb_q.delete();
    end
  endtask

  task automatic wait_tick(input int budget);
    int n;
    n = 0;
    do begin
      cycle();
      n++;
    end while ((tick !== 1'b1) && (n < budget));
    if (tick !== 1'b1) begin
      check("tick_timeout", 32'(tick), 32'd1);
    end
  endtask

  task automatic ped_pulse();
    ped_req = 1'b1;
    cycle();
    ped_req = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_phase"}, 32'(phase), 32'd5);
    check({tag, "_remain"}, 32'(remain), 32'd0);
    check({tag, "_ns"}, 32'(ns_light), 32'd4);
    check({tag, "_ew"}, 32'(ew_light), 32'd4);
    check({tag, "_tick"}, 32'(tick), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    errors    = 0;
    checks    = 0;
    sec_cnt   = 0;
    sec_run   = 1'b0;
    prev_tick = 1'b0;
    rst       = 1'b1;
    sec_in    = 1'b1;
    ped_req   = 1'b0;

    // Reset with sec_in already high.
    repeat (3) cycle();
    rst = 1'b0;
    check_reset_vals("reset");
    repeat (6) begin
      cycle();
      check("no_false_tick", 32'(tick), 32'd0);
    end

    // Start the 10-clk square wave from low.
    sec_in  = 1'b0;
    sec_cnt = 0;
    sec_run = 1'b1;

    // Full cycle, no pedestrian.
    push(NS_G, 6'd3); push(NS_G, 6'd2); push(NS_G, 6'd1); push(NS_G, 6'd0);
    push(NS_Y, 6'd1); push(NS_Y, 6'd0); push(AR1, 6'd0);
    push(EW_G, 6'd3); push(EW_G, 6'd2); push(EW_G, 6'd1); push(EW_G, 6'd0);
    push(EW_Y, 6'd1); push(EW_Y, 6'd0); push(AR2, 6'd0);
    drain(200);

    // Pedestrian during NS green at remain=3; cleared by NS yellow entry.
    push(NS_G, 6'd3);
    drain(30);
    ped_pulse();
    push(NS_G, 6'd1); push(NS_G, 6'd0); push(NS_Y, 6'd1); push(NS_Y, 6'd0);
    push(AR1, 6'd0);
    push(EW_G, 6'd3); push(EW_G, 6'd2); push(EW_G, 6'd1); push(EW_G, 6'd0);
    push(EW_Y, 6'd1); push(EW_Y, 6'd0); push(AR2, 6'd0);
    drain(200);

    // Pedestrian during NS yellow: waits for EW green.
    push(NS_G, 6'd3); push(NS_G, 6'd2); push(NS_G, 6'd1); push(NS_G, 6'd0);
    push(NS_Y, 6'd1);
    drain(100);
    ped_pulse();
    push(NS_Y, 6'd0); push(AR1, 6'd0);
    push(EW_G, 6'd3); push(EW_G, 6'd1); push(EW_G, 6'd0);
    push(EW_Y, 6'd1); push(EW_Y, 6'd0); push(AR2, 6'd0);
    drain(200);

    // Request on the very clk of NS yellow entry: set wins.
    push(NS_G, 6'd3); push(NS_G, 6'd2); push(NS_G, 6'd1); push(NS_G, 6'd0);
    drain(100);
    push(NS_Y, 6'd1);
    wait_tick(30);
    ped_pulse();
    push(NS_Y, 6'd0); push(AR1, 6'd0);
    push(EW_G, 6'd3); push(EW_G, 6'd1); push(EW_G, 6'd0);
    push(EW_Y, 6'd1); push(EW_Y, 6'd0); push(AR2, 6'd0);
    drain(200);

    // Reset in the middle of EW green.
    push(NS_G, 6'd3); push(NS_G, 6'd2); push(NS_G, 6'd1); push(NS_G, 6'd0);
    push(NS_Y, 6'd1); push(NS_Y, 6'd0); push(AR1, 6'd0);
    push(EW_G, 6'd3); push(EW_G, 6'd2);
    drain(200);
    check("pre_rst_phase", 32'(phase), 32'd3);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check_reset_vals("mid_rst");
    push(NS_G, 6'd3);
    drain(40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
